// File: rtl/hc194_ctrl.sv
// Sequencer for a 74HC194 universal shift register: turns one-shot LOAD/SHR/SHL
// commands into the chip's mode, serial and parallel inputs, with busy/done handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; chip held (S=00)
// ST_LOAD  | one cycle of parallel load (S=11, D=captured data)
// ST_SHIFT | one chip shift per cycle until the remaining count runs out
// ST_DONE  | one-cycle completion pulse, then back to idle

module hc194_ctrl #(
    parameter int CNT_W = 3
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             rot,
    input  logic             fill,
    input  logic [CNT_W-1:0] count,
    input  logic [3:0]       data,
    input  logic [3:0]       q_in,
    output logic [1:0]       S,
    output logic             DSR,
    output logic             DSL,
    output logic [3:0]       D,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             rot_q, rot_d;
    logic             fill_q, fill_d;
    logic [3:0]       data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             serial_bit;

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            state_q <= ST_IDLE;
            op_q    <= 2'b00;
            rot_q   <= 1'b0;
            fill_q  <= 1'b0;
            data_q  <= 4'b0000;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rot_q   <= rot_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rot_d   = rot_q;
        fill_d  = fill_q;
        data_d  = data_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = op;
                    rot_d  = rot;
                    fill_d = fill;
                    data_d = data;
                    rem_d  = count;
                    if (op == OP_LOAD)
                        state_d = ST_LOAD;
                    else if ((op == OP_SHR || op == OP_SHL) && count != '0)
                        state_d = ST_SHIFT;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_LOAD:  state_d = ST_DONE;
            ST_SHIFT: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1))
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Rotation feeds back the bit about to fall off the far end of the chip.
    assign serial_bit = rot_q ? ((op_q == OP_SHR) ? q_in[3] : q_in[0]) : fill_q;

    always_comb begin
        S    = MODE_HOLD;
        DSR  = 1'b0;
        DSL  = 1'b0;
        D    = 4'b0000;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_LOAD: begin
                S    = MODE_LOAD;
                D    = data_q;
                busy = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (op_q == OP_SHR) begin
                    S   = OP_SHR;
                    DSR = serial_bit;
                end else begin
                    S   = OP_SHL;
                    DSL = serial_bit;
                end
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hc194_ctrl.sv
// Bench for hc194_ctrl: a behavioural HC194 closes the loop on q_in, and a
// per-cycle expectation model derived from the command rules checks every output.

module tb_hc194_ctrl;

    localparam int CNT_W = 3;

    logic             Clk = 1'b0;
    logic             MR = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic             rot = 1'b0;
    logic             fill = 1'b0;
    logic [CNT_W-1:0] count = '0;
    logic [3:0]       data = 4'b0000;
    logic [3:0]       q_chip;
    logic [1:0]       S;
    logic             DSR, DSL, busy, done;
    logic [3:0]       D;
    logic [9:0]       obs;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] ref_q = 4'b0000;

    hc194_ctrl #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .MR(MR), .start(start), .op(op), .rot(rot), .fill(fill),
        .count(count), .data(data), .q_in(q_chip),
        .S(S), .DSR(DSR), .DSL(DSL), .D(D), .busy(busy), .done(done)
    );

    assign obs = {S, busy, done, D, DSR, DSL};

    always #5 Clk = ~Clk;

    // Behavioural 74HC194 sharing the MR net.
    always @(posedge Clk or negedge MR) begin
        if (!MR) q_chip <= 4'b0000;
        else begin
            case (S)
                2'b01: q_chip <= {q_chip[2:0], DSR};
                2'b10: q_chip <= {DSL, q_chip[3:1]};
                2'b11: q_chip <= D;
                default: q_chip <= q_chip;
            endcase
        end
    end

    function automatic logic [3:0] ref_step(logic [3:0] q, logic [1:0] o, logic r, logic f);
        if (o == 2'b01) return {q[2:0], r ? q[3] : f};
        if (o == 2'b10) return {r ? q[0] : f, q[3:1]};
        return q;
    endfunction

    function automatic int cmd_len(logic [1:0] o, int n);
        if (o == 2'b00) return 2;
        if ((o == 2'b01 || o == 2'b10) && n > 0) return n + 1;
        return 1;
    endfunction

    function automatic logic [3:0] ref_final(logic [3:0] q0, logic [1:0] o, logic r, logic f,
                                             int n, logic [3:0] d);
        logic [3:0] q;
        if (o == 2'b00) return d;
        q = q0;
        if (o == 2'b01 || o == 2'b10)
            for (int i = 0; i < n; i++) q = ref_step(q, o, r, f);
        return q;
    endfunction

    // Expected {S,busy,done,D,DSR,DSL} in cycle k after the accepting edge.
    function automatic logic [9:0] exp_vec(logic [1:0] o, logic r, logic f, int n,
                                           logic [3:0] d, logic [3:0] q0, int k);
        logic [3:0] q;
        logic       sb;
        int         len;
        len = cmd_len(o, n);
        if (k > len)  return 10'b0;
        if (k == len) return {2'b00, 1'b1, 1'b1, 4'b0000, 2'b00};
        if (o == 2'b00) return {2'b11, 1'b1, 1'b0, d, 2'b00};
        q = q0;
        for (int i = 0; i < k - 1; i++) q = ref_step(q, o, r, f);
        sb = r ? ((o == 2'b01) ? q[3] : q[0]) : f;
        return {o, 1'b1, 1'b0, 4'b0000, (o == 2'b01) ? sb : 1'b0, (o == 2'b10) ? sb : 1'b0};
    endfunction

    task automatic issue(input logic [1:0] o, input logic r, input logic f, input int n,
                         input logic [3:0] d);
        start = 1'b1;
        op    = o;
        rot   = r;
        fill  = f;
        count = n[CNT_W-1:0];
        data  = d;
        @(posedge Clk);
    endtask

    task automatic noise();
        start = 1'($urandom);
        op    = 2'($urandom);
        rot   = 1'($urandom);
        fill  = 1'($urandom);
        count = CNT_W'($urandom);
        data  = 4'($urandom);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs !== 10'b0 || q_chip !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state got obs=%b q=%b exp obs=0 q=0000", obs, q_chip);
        end
        @(negedge Clk);
        MR = 1'b1;
        ref_q = 4'b0000;
    endtask

    task automatic test_load();
        logic [3:0] q0;
        q0 = ref_q;
        issue(2'b00, 1'b0, 1'b0, 0, 4'b1010);
        for (int k = 1; k <= 3; k++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp_vec(2'b00, 1'b0, 1'b0, 0, 4'b1010, q0, k)) begin
                failures++;
                $display("FAIL load k=%0d got=%b exp=%b", k, obs,
                         exp_vec(2'b00, 1'b0, 1'b0, 0, 4'b1010, q0, k));
            end
            if (k < 3) noise(); else start = 1'b0;
        end
        ref_q = 4'b1010;
        checks++;
        if (q_chip !== 4'b1010) begin
            failures++;
            $display("FAIL load_q got=%b exp=1010", q_chip);
        end
    endtask

    task automatic test_shift_right_fill();
        logic [3:0] q0;
        q0 = ref_q;
        issue(2'b01, 1'b0, 1'b1, 2, 4'b0000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp_vec(2'b01, 1'b0, 1'b1, 2, 4'b0000, q0, k)) begin
                failures++;
                $display("FAIL shr_fill k=%0d got=%b exp=%b", k, obs,
                         exp_vec(2'b01, 1'b0, 1'b1, 2, 4'b0000, q0, k));
            end
            if (k < 4) noise(); else start = 1'b0;
        end
        ref_q = 4'b1011;
        checks++;
        if (q_chip !== 4'b1011) begin
            failures++;
            $display("FAIL shr_fill_q got=%b exp=1011", q_chip);
        end
    endtask

    task automatic test_rotate_left();
        logic [3:0] q0;
        issue(2'b00, 1'b0, 1'b0, 0, 4'b0001);
        repeat (3) @(negedge Clk);
        start = 1'b0;
        q0 = 4'b0001;
        checks++;
        if (q_chip !== q0) begin
            failures++;
            $display("FAIL rotl_preload got=%b exp=0001", q_chip);
        end
        issue(2'b10, 1'b1, 1'b0, 3, 4'b1111);
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp_vec(2'b10, 1'b1, 1'b0, 3, 4'b1111, q0, k)) begin
                failures++;
                $display("FAIL rotl k=%0d got=%b exp=%b", k, obs,
                         exp_vec(2'b10, 1'b1, 1'b0, 3, 4'b1111, q0, k));
            end
            if (k < 5) noise(); else start = 1'b0;
        end
        ref_q = 4'b0010;
        checks++;
        if (q_chip !== 4'b0010) begin
            failures++;
            $display("FAIL rotl_q got=%b exp=0010", q_chip);
        end
    endtask

    task automatic test_noop();
        logic [3:0] q0;
        logic [1:0] o;
        for (int c = 0; c < 2; c++) begin
            q0 = ref_q;
            o  = (c == 0) ? 2'b01 : 2'b11;
            issue(o, 1'b1, 1'b1, (c == 0) ? 0 : 5, 4'b0110);
            for (int k = 1; k <= 2; k++) begin
                @(negedge Clk);
                checks++;
                if (obs !== exp_vec(o, 1'b1, 1'b1, (c == 0) ? 0 : 5, 4'b0110, q0, k)) begin
                    failures++;
                    $display("FAIL noop op=%b k=%0d got=%b exp=%b", o, k, obs,
                             exp_vec(o, 1'b1, 1'b1, (c == 0) ? 0 : 5, 4'b0110, q0, k));
                end
                if (k < 2) noise(); else start = 1'b0;
            end
            checks++;
            if (q_chip !== q0) begin
                failures++;
                $display("FAIL noop_q op=%b got=%b exp=%b", o, q_chip, q0);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [3:0] q0;
        int         done_cnt;
        int         shift_cnt;
        q0 = ref_q;
        done_cnt = 0;
        shift_cnt = 0;
        issue(2'b01, 1'b0, 1'b0, 4, 4'b0000);
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            if (done) done_cnt++;
            if (S == 2'b01) shift_cnt++;
            checks++;
            if (obs !== exp_vec(2'b01, 1'b0, 1'b0, 4, 4'b0000, q0, k)) begin
                failures++;
                $display("FAIL ignore_busy k=%0d got=%b exp=%b", k, obs,
                         exp_vec(2'b01, 1'b0, 1'b0, 4, 4'b0000, q0, k));
            end
            start = (k < 6);
            op    = 2'b00;
            data  = 4'($urandom);
        end
        ref_q = ref_final(q0, 2'b01, 1'b0, 1'b0, 4, 4'b0000);
        checks++;
        if (done_cnt != 1 || shift_cnt != 4 || q_chip !== ref_q) begin
            failures++;
            $display("FAIL ignore_busy_tot got done=%0d shifts=%0d q=%b exp 1 4 %b",
                     done_cnt, shift_cnt, q_chip, ref_q);
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b01, 1'b0, 1'b1, 5, 4'b0000);
        repeat (2) @(negedge Clk);
        start = 1'b1;
        #2 MR = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0 || q_chip !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid got obs=%b q=%b exp obs=0 q=0000", obs, q_chip);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++;
            if (obs !== 10'b0) begin
                failures++;
                $display("FAIL reset_hold k=%0d got=%b exp=0", k, obs);
            end
        end
        ref_q = 4'b0000;
        MR = 1'b1;
        issue(2'b11, 1'b0, 1'b0, 0, 4'b0000);
        for (int k = 1; k <= 2; k++) begin
            @(negedge Clk);
            checks++;
            if (obs !== exp_vec(2'b11, 1'b0, 1'b0, 0, 4'b0000, ref_q, k)) begin
                failures++;
                $display("FAIL first_accept k=%0d got=%b exp=%b", k, obs,
                         exp_vec(2'b11, 1'b0, 1'b0, 0, 4'b0000, ref_q, k));
            end
            start = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] o;
        logic       r, f;
        logic [3:0] d, q0;
        int         n, len;
        for (int c = 0; c < 30; c++) begin
            o = 2'($urandom);
            r = 1'($urandom);
            f = 1'($urandom);
            d = 4'($urandom);
            n = int'($urandom_range(0, 7));
            q0 = ref_q;
            len = cmd_len(o, n);
            issue(o, r, f, n, d);
            for (int k = 1; k <= len + 1; k++) begin
                @(negedge Clk);
                checks++;
                if (obs !== exp_vec(o, r, f, n, d, q0, k)) begin
                    failures++;
                    $display("FAIL b2b c=%0d op=%b n=%0d k=%0d got=%b exp=%b", c, o, n, k, obs,
                             exp_vec(o, r, f, n, d, q0, k));
                end
                if (k <= len) noise(); else start = 1'b0;
            end
            ref_q = ref_final(q0, o, r, f, n, d);
            checks++;
            if (q_chip !== ref_q) begin
                failures++;
                $display("FAIL b2b_q c=%0d got=%b exp=%b", c, q_chip, ref_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right_fill();
        test_rotate_left();
        test_noop();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
